// File: rtl/exec_sequencer.sv
// Single-issue instruction sequencer: 8x8 register file, IDLE/READ/EXEC/WB control,
// operands and opcode registered toward an external ALU, result written back in WB.
module exec_sequencer #(
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] fun,
  input  logic [2:0] sel_y,
  input  logic [2:0] sel_x,
  input  logic [2:0] sel_d,
  input  logic       load_en,
  input  logic [2:0] load_addr,
  input  logic [7:0] load_data,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [2:0] fun_alu,
  output logic [7:0] Ry,
  output logic [7:0] Rx,
  input  logic [7:0] Result,
  input  logic [2:0] band,
  output logic [2:0] flags,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  typedef struct packed {
    logic [2:0] fun;
    logic [2:0] sel_y;
    logic [2:0] sel_x;
    logic [2:0] sel_d;
  } instr_t;

  state_t          state, state_nxt;
  instr_t          instr_q;
  logic [7:0][7:0] regs;
  logic [7:0]      res_q;
  logic            accept, rd_en, ex_en, wb_en, ld_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rd_en     = 1'b0;
    ex_en     = 1'b0;
    wb_en     = 1'b0;
    ld_en     = 1'b0;
    case (state)
      IDLE: begin
        ld_en = load_en;
        if (start) begin
          accept    = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        rd_en     = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        ex_en     = 1'b1;
        state_nxt = WB;
      end
      WB: begin
        wb_en     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign done    = (state == WB);
  assign rd_data = regs[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      fun_alu <= 3'b000;
      Ry      <= 8'h00;
      Rx      <= 8'h00;
      res_q   <= 8'h00;
      flags   <= 3'b000;
    end else begin
      if (accept) instr_q <= '{fun: fun, sel_y: sel_y, sel_x: sel_x, sel_d: sel_d};
      if (rd_en) begin
        Ry      <= regs[instr_q.sel_y];
        Rx      <= regs[instr_q.sel_x];
        fun_alu <= instr_q.fun;
      end
      if (ex_en) begin
        res_q <= Result;
        flags <= band;
      end
    end
  end

  // Load and write-back live in disjoint states, so one write port suffices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= REG_INIT;
    end else if (ld_en) begin
      regs[load_addr] <= load_data;
    end else if (wb_en) begin
      regs[instr_q.sel_d] <= res_q;
    end
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter: REG_INIT, default 8'h00, reset value of every register-file entry.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to execute one instruction; sampled only in IDLE.
REQ-005 fun  input  3  ALU operation code for the requested instruction.
REQ-006 sel_y  input  3  register index of the first operand (drives Ry).
REQ-007 sel_x  input  3  register index of the second operand (drives Rx).
REQ-008 sel_d  input  3  destination register index for the result.
REQ-009 load_en  input  1  external register write strobe; honoured only in IDLE.
REQ-010 load_addr  input  3  external write index.
REQ-011 load_data  input  8  external write data.
REQ-012 rd_addr  input  3  debug read index.
REQ-013 rd_data  output  8  combinational read of register rd_addr.
REQ-014 fun_alu  output  3  registered operation code to the ALU.
REQ-015 Ry  output  8  registered first operand to the ALU.
REQ-016 Rx  output  8  registered second operand to the ALU.
REQ-017 Result  input  8  ALU result.
REQ-018 band  input  3  ALU flags: [0] zero, [1] sign (bit 7), [2] carry/borrow.
REQ-019 flags  output  3  registered copy of band from the last executed instruction.
REQ-020 busy  output  1  high in READ, EXEC and WB.
REQ-021 done  output  1  high exactly one cycle, in WB.

Function
REQ-022 Register file: 8 entries x 8 bits, no hardwired entries.
REQ-023 FSM states: IDLE, READ, EXEC, WB; IDLE->READ on start=1; READ->EXEC, EXEC->WB, WB->IDLE unconditionally.
REQ-024 Edge E0 (IDLE, start=1): latch fun, sel_y, sel_x, sel_d into internal instruction registers.
REQ-025 Edge E1 (leaving READ): Ry<=reg[sel_y_q], Rx<=reg[sel_x_q], fun_alu<=fun_q.
REQ-026 Edge E2 (leaving EXEC): capture Result into res_q; flags<=band.
REQ-027 Edge E3 (leaving WB): reg[sel_d_q]<=res_q; done is high in the WB cycle between E2 and E3.
REQ-028 Latency: done is high in the third cycle after the start-sampling edge; the next start is accepted at E3+1 at the earliest.
REQ-029 start while busy=1 is ignored, with no queuing.
REQ-030 load_en while busy=1 is ignored; in IDLE, reg[load_addr]<=load_data at the edge.
REQ-031 load_en and start in the same IDLE cycle: the load and the start both take effect, and the READ at E1 sees the loaded value.
REQ-032 sel_d equal to sel_y or sel_x: operands use the pre-write values (read at E1 precedes write at E3).
REQ-033 Back-to-back instructions: the second instruction's READ sees the first instruction's write-back.
REQ-034 Ry, Rx and fun_alu hold their values from E1 until the next E1; flags hold until the next E2.

Reset
REQ-035 rst=1 forces, asynchronously: state=IDLE, busy=0, done=0, Ry=Rx=8'h00, fun_alu=3'b000, flags=3'b000, res_q=8'h00, all registers=REG_INIT.
REQ-036 rst asserted mid-instruction aborts the instruction: no write-back, no done pulse.
REQ-037 The first start is accepted at the first rising edge after rst deasserts.

Verification
REQ-038 Load r1=8'h0F, r2=8'h01; start fun=000, sel_y=1, sel_x=2, sel_d=3 -> done in the 3rd cycle after the start edge, then r3=8'h10, flags=3'b000.
REQ-039 r4=8'h05, r5=8'h05; fun=001, sel_y=4, sel_x=5, sel_d=6 -> r6=8'h00, flags[0]=1.
REQ-040 r1=8'h80, r2=8'h80; fun=000, sel_d=1 -> r1=8'h00, flags[2]=1; Ry at E1 = 8'h80 (old value).
REQ-041 Pulse start again in READ and in WB -> ignored: exactly one done, busy low for one cycle before the next accepted start.
REQ-042 Assert rst in EXEC -> busy=0 immediately, no done, every register reads 8'h00 via rd_data, flags=3'b000.
REQ-043 In IDLE, load_en with load_addr=2, load_data=8'hAA and start (sel_y=2) in the same cycle -> Ry=8'hAA after E1.
